// File: rtl/e203_exu_flush_redirect_pkg.sv
// Shared definitions for the EXU flush/redirect block: widths, flush sources and state encoding.
package e203_flush_pkg;

    localparam int PC_SIZE_DEF = 32;

    localparam logic FLUSH_SRC_BRCH = 1'b0;
    localparam logic FLUSH_SRC_EXCP = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } flush_state_e;

endpackage

// File: rtl/e203_exu_flush_redirect_if.sv
// Flush request/ack bundle between EXU commit logic, the redirect unit and the IFU.
interface e203_exu_flush_redirect_if #(
    parameter int PC_SIZE = e203_flush_pkg::PC_SIZE_DEF
) ();

    logic               brchmis_flush_req;
    logic [PC_SIZE-1:0] brchmis_flush_add_op1;
    logic [PC_SIZE-1:0] brchmis_flush_add_op2;
    logic               brchmis_flush_ack;

    logic               excpirq_flush_req;
    logic [PC_SIZE-1:0] excpirq_flush_add_op1;
    logic [PC_SIZE-1:0] excpirq_flush_add_op2;
    logic               excpirq_flush_ack;

    logic               pipe_flush_req;
    logic [PC_SIZE-1:0] pipe_flush_pc;
    logic               pipe_flush_src;
    logic               pipe_flush_ack;

    logic               flush_pend;

    // The redirect unit itself
    modport master (
        input  brchmis_flush_req, brchmis_flush_add_op1, brchmis_flush_add_op2,
        input  excpirq_flush_req, excpirq_flush_add_op1, excpirq_flush_add_op2,
        input  pipe_flush_ack,
        output brchmis_flush_ack, excpirq_flush_ack,
        output pipe_flush_req, pipe_flush_pc, pipe_flush_src, flush_pend
    );

    // Surrounding EXU commit logic and IFU
    modport slave (
        output brchmis_flush_req, brchmis_flush_add_op1, brchmis_flush_add_op2,
        output excpirq_flush_req, excpirq_flush_add_op1, excpirq_flush_add_op2,
        output pipe_flush_ack,
        input  brchmis_flush_ack, excpirq_flush_ack,
        input  pipe_flush_req, pipe_flush_pc, pipe_flush_src, flush_pend
    );

endinterface

// File: rtl/e203_exu_flush_redirect.sv
// Arbitrates branch vs exception/IRQ flushes, computes the redirect PC and holds it
// towards the IFU until acknowledged.
module e203_exu_flush_redirect
    import e203_flush_pkg::*;
#(
    parameter int               PC_SIZE  = PC_SIZE_DEF,
    parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    e203_exu_flush_redirect_if.master   flush_if
);

    flush_state_e       state_q, state_d;
    logic [PC_SIZE-1:0] pc_q, pc_d;
    logic               src_q, src_d;

    logic               can_accept;
    logic               excp_ack;
    logic               brch_ack;
    logic [PC_SIZE-1:0] add_op1;
    logic [PC_SIZE-1:0] add_op2;
    logic [PC_SIZE-1:0] add_sum;
    logic [PC_SIZE-1:0] target_pc;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        src_d     = src_q;

        // A new flush may be taken when idle, or when the IFU is consuming the held one
        can_accept = (state_q == IDLE) | ((state_q == PEND) & flush_if.pipe_flush_ack);
        excp_ack   = ~rst & can_accept & flush_if.excpirq_flush_req;
        brch_ack   = ~rst & can_accept & flush_if.brchmis_flush_req & ~flush_if.excpirq_flush_req;

        add_op1   = flush_if.excpirq_flush_req ? flush_if.excpirq_flush_add_op1
                                               : flush_if.brchmis_flush_add_op1;
        add_op2   = flush_if.excpirq_flush_req ? flush_if.excpirq_flush_add_op2
                                               : flush_if.brchmis_flush_add_op2;
        add_sum   = add_op1 + add_op2;
        target_pc = {add_sum[PC_SIZE-1:1], 1'b0};

        if ((state_q == PEND) && flush_if.pipe_flush_ack) begin
            state_d = IDLE;
        end
        if (excp_ack || brch_ack) begin
            state_d = PEND;
            pc_d    = target_pc;
            src_d   = excp_ack ? FLUSH_SRC_EXCP : FLUSH_SRC_BRCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            src_q   <= FLUSH_SRC_BRCH;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            src_q   <= src_d;
        end
    end

    assign flush_if.excpirq_flush_ack = excp_ack;
    assign flush_if.brchmis_flush_ack = brch_ack;
    assign flush_if.pipe_flush_req    = (state_q == PEND);
    assign flush_if.pipe_flush_pc     = pc_q;
    assign flush_if.pipe_flush_src    = src_q;
    assign flush_if.flush_pend        = ~rst & (state_q == PEND) & ~flush_if.pipe_flush_ack;

endmodule
